// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and decode helpers for ctrl_seq_decoder.
//   OpcW/CtrlW/MaxBeats - default widths; the decode table below is sized by them
//   beat_t              - beat index type for the default MaxBeats
//   state_e             - sequencer states (StIdle: no word presented, StEmit: word presented)
//   is_reserved(opc)    - top two opcode bits both set
//   ctrl_base(opc)      - per-opcode control bits, excluding enable and first-beat strobe
package ctrl_seq_pkg;

  localparam int unsigned OpcW     = 7;
  localparam int unsigned CtrlW    = 26;
  localparam int unsigned MaxBeats = 4;
  localparam int unsigned BeatW    = $clog2(MaxBeats);

  typedef logic [BeatW-1:0] beat_t;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  function automatic logic is_reserved(input logic [OpcW-1:0] opc);
    return opc[OpcW-1 -: 2] == 2'b11;
  endfunction

  // Bit 0 (first-beat strobe) and bit CtrlW-1 (enable) are never set here.
  //   bits 9:2   one-hot unit select from opc[4:2]
  //   bits 11:10 opc[1:0] (beat count minus one)
  //   bit  1     multi-beat opcode
  //   bits 15:12 one-hot class from opc[6:5]
  // NOP (opc == 0) decodes to no bits at all.
  function automatic logic [CtrlW-1:0] ctrl_base(input logic [OpcW-1:0] opc);
    logic [CtrlW-1:0] b;
    b = '0;
    if (opc != '0) begin
      b        = b | (CtrlW'(1) << (32'd2 + 32'(opc[4:2])));
      b        = b | (CtrlW'(1) << (32'd12 + 32'(opc[6:5])));
      b[11:10] = opc[1:0];
      b[1]     = |opc[1:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/ctrl_seq_perf.sv
// ctrl_seq_perf: two saturating 32-bit event counters, cleared only by reset.
//   clk, rst_n      - clock, async active-low reset
//   instr_inc_i     - count one accepted opcode
//   stall_inc_i     - count one stalled output cycle
//   perf_instr_o    - accepted opcode count
//   perf_stall_o    - stalled cycle count
module ctrl_seq_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] perf_instr_o,
  output logic [31:0] perf_stall_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    instr_d = instr_q;
    stall_d = stall_q;
    if (instr_inc_i && (instr_q != '1)) instr_d = instr_q + 32'd1;
    if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  assign perf_instr_o = instr_q;
  assign perf_stall_o = stall_q;

endmodule

// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: registered multi-beat control decoder. Accepts one opcode per
// in_valid/in_ready handshake and presents 1..MAX_BEATS control words on a
// valid/ready output, each tagged with its beat index and a last flag.
//   clk, rst_n              - clock, async active-low reset
//   flush_i                 - drop the in-flight opcode at the next edge
//   in_valid_i/in_ready_o   - opcode handshake; in_opc_i is the opcode
//   out_valid_o/out_ready_i - control word handshake
//   out_ctrl_o/out_beat_o   - control word and 0-based beat index
//   out_last_o              - final beat of the opcode
//   illegal_o               - one-cycle pulse while beat 0 of a reserved opcode is shown
//   perf_instr_o/_stall_o   - performance counters, present when CTRL_SEQ_PERF_EN is
//                             defined, otherwise tied to zero
module ctrl_seq_decoder
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPC_W     = OpcW,
  parameter int unsigned CTRL_W    = CtrlW,
  parameter int unsigned MAX_BEATS = MaxBeats,
  localparam int unsigned BEAT_W   = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OPC_W-1:0]  in_opc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [BEAT_W-1:0] out_beat_o,
  output logic              out_last_o,
  output logic              illegal_o,
  output logic [31:0]       perf_instr_o,
  output logic [31:0]       perf_stall_o
);

  function automatic logic [CTRL_W-1:0] make_word(input logic [OPC_W-1:0] opc,
                                                  input logic first);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[CTRL_W-1] = 1'b1;
    if (!is_reserved(OpcW'(opc))) begin
      w    = w | CTRL_W'(ctrl_base(OpcW'(opc)));
      w[0] = w[0] | first;
    end
    return w;
  endfunction

  // Index of the last beat: opc[1:0] clamped to MAX_BEATS-1, reserved is single-beat.
  function automatic logic [BEAT_W-1:0] last_beat(input logic [OPC_W-1:0] opc);
    if (is_reserved(OpcW'(opc))) return '0;
    if (32'(opc[1:0]) >= MAX_BEATS) return BEAT_W'(MAX_BEATS - 1);
    return BEAT_W'(opc[1:0]);
  endfunction

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] last_idx_q, last_idx_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              last_q, last_d;
  logic              illegal_q, illegal_d;

  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic [BEAT_W-1:0] new_last_idx;

  assign out_valid    = (state_q == StEmit);
  assign in_ready     = ~flush_i & (~out_valid | (out_ready_i & last_q));
  assign accept       = in_valid_i & in_ready;
  assign new_last_idx = last_beat(in_opc_i);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_idx_d = last_idx_q;
    opc_d      = opc_q;
    ctrl_d     = ctrl_q;
    last_d     = last_q;
    illegal_d  = 1'b0;

    if (flush_i) begin
      state_d = StIdle;
      beat_d  = '0;
      ctrl_d  = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      // Covers both IDLE and the last-beat handshake in EMIT, so a new opcode
      // follows back-to-back without a bubble.
      state_d    = StEmit;
      beat_d     = '0;
      last_idx_d = new_last_idx;
      opc_d      = in_opc_i;
      ctrl_d     = make_word(in_opc_i, 1'b1);
      last_d     = (new_last_idx == '0);
      illegal_d  = is_reserved(OpcW'(in_opc_i));
    end else begin
      unique case (state_q)
        StIdle: ;
        StEmit: begin
          if (out_ready_i) begin
            if (last_q) begin
              state_d = StIdle;
              beat_d  = '0;
              ctrl_d  = '0;
              last_d  = 1'b0;
            end else begin
              beat_d = beat_q + 1'b1;
              ctrl_d = make_word(opc_q, 1'b0);
              last_d = (beat_d == last_idx_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      last_idx_q <= '0;
      opc_q      <= '0;
      ctrl_q     <= '0;
      last_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_idx_q <= last_idx_d;
      opc_q      <= opc_d;
      ctrl_q     <= ctrl_d;
      last_q     <= last_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign out_ctrl_o  = ctrl_q;
  assign out_beat_o  = beat_q;
  assign out_last_o  = last_q;
  assign illegal_o   = illegal_q;

`ifdef CTRL_SEQ_PERF_EN
  logic stall;
  assign stall = out_valid & ~out_ready_i;

  ctrl_seq_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_inc_i  (accept),
    .stall_inc_i  (stall),
    .perf_instr_o (perf_instr_o),
    .perf_stall_o (perf_stall_o)
  );
`else
  assign perf_instr_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
module tb_ctrl_seq_decoder;
  import ctrl_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opc;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_ctrl;
  logic [1:0]  out_beat;
  logic        out_last;
  logic        illegal;
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;

  ctrl_seq_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_opc_i     (in_opc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_ctrl_o   (out_ctrl),
    .out_beat_o   (out_beat),
    .out_last_o   (out_last),
    .illegal_o    (illegal),
    .perf_instr_o (perf_instr),
    .perf_stall_o (perf_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of words still to be presented ----------
  typedef struct packed {
    logic [25:0] ctrl;
    beat_t       beat;
    logic        last;
  } word_t;

  word_t       pend[$];
  logic        m_ill;
  int unsigned m_instr;
  int unsigned m_stall;

  function automatic logic [25:0] exp_word(input logic [6:0] opc, input int beat);
    if (is_reserved(opc)) return 26'h200_0000;
    return ctrl_base(opc) | 26'h200_0000 | ((beat == 0) ? 26'd1 : 26'd0);
  endfunction

  function automatic int n_beats(input logic [6:0] opc);
    int n;
    if (is_reserved(opc)) return 1;
    n = int'(opc[1:0]) + 1;
    if (n > int'(MaxBeats)) n = int'(MaxBeats);
    return n;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ill   = 1'b0;
    m_instr = 0;
    m_stall = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":out_valid"}, 32'(out_valid), 32'(pend.size() > 0));
    if (pend.size() > 0) begin
      check({tag, ":out_ctrl"}, 32'(out_ctrl), 32'(pend[0].ctrl));
      check({tag, ":out_beat"}, 32'(out_beat), 32'(pend[0].beat));
      check({tag, ":out_last"}, 32'(out_last), 32'(pend[0].last));
    end
    check({tag, ":illegal"}, 32'(illegal), 32'(m_ill));
`ifdef CTRL_SEQ_PERF_EN
    check({tag, ":perf_instr"}, perf_instr, m_instr);
    check({tag, ":perf_stall"}, perf_stall, m_stall);
`else
    check({tag, ":perf_instr"}, perf_instr, 32'd0);
    check({tag, ":perf_stall"}, perf_stall, 32'd0);
`endif
  endtask

  // Called at posedge+1; drives inputs, checks in_ready, crosses one edge, checks outputs.
  task automatic cycle(input string tag, input logic f, input logic iv,
                       input logic [6:0] opc, input logic ordy);
    logic exp_rdy, acc, hs, stl;
    flush     = f;
    in_valid  = iv;
    in_opc    = opc;
    out_ready = ordy;
    #1;
    exp_rdy = !f && ((pend.size() == 0) || (ordy && pend.size() == 1));
    check({tag, ":in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = iv && exp_rdy;
    hs  = (pend.size() > 0) && ordy && !f;
    stl = (pend.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    if (acc && m_instr != 32'hFFFF_FFFF) m_instr++;
    if (stl && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_ill = 1'b0;
    if (f) begin
      pend.delete();
    end else begin
      if (hs) pend.delete(0);
      if (acc) begin
        for (int b = 0; b < n_beats(opc); b++) begin
          pend.push_back('{ctrl: exp_word(opc, b), beat: beat_t'(b),
                           last: (b == n_beats(opc) - 1)});
        end
        m_ill = is_reserved(opc);
      end
    end
    check_outputs(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fl;
    logic        iv;
    logic [6:0]  opc;
    logic        ordy;
    logic        rdy;
    logic        v;
    logic [25:0] ctrl;
    logic [1:0]  beat;
    logic        last;
    logic        ill;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [6:0] opc,
                              input logic ordy, input logic rdy, input logic v,
                              input logic [25:0] ctrl, input logic [1:0] beat,
                              input logic last, input logic ill);
    vec_t r;
    r.fl = fl; r.iv = iv; r.opc = opc; r.ordy = ordy; r.rdy = rdy;
    r.v = v; r.ctrl = ctrl; r.beat = beat; r.last = last; r.ill = ill;
    return r;
  endfunction

  task automatic apply_reset_checked();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_opc    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:out_ctrl", 32'(out_ctrl), 32'd0);
    check("reset:out_beat", 32'(out_beat), 32'd0);
    check("reset:out_last", 32'(out_last), 32'd0);
    check("reset:illegal", 32'(illegal), 32'd0);
    check("reset:perf_instr", perf_instr, 32'd0);
    check("reset:perf_stall", perf_stall, 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset:in_ready", 32'(in_ready), 32'd1);
    model_reset();
  endtask

  initial begin
    logic [31:0] s0;

    // Words hand-derived from the decode table.
    //   fl iv opc    ordy rdy v  ctrl          beat last ill
    tbl[0]  = mk(0, 1, 7'h04, 1, 1, 1, 26'h200_1009, 0, 1, 0);
    tbl[1]  = mk(0, 1, 7'h08, 1, 1, 1, 26'h200_1011, 0, 1, 0);
    tbl[2]  = mk(0, 1, 7'h0C, 1, 1, 1, 26'h200_1021, 0, 1, 0);
    tbl[3]  = mk(0, 0, 7'h00, 1, 1, 0, 26'h000_0000, 0, 0, 0);
    tbl[4]  = mk(0, 1, 7'h07, 1, 1, 1, 26'h200_1C0B, 0, 0, 0);
    tbl[5]  = mk(0, 1, 7'h04, 1, 0, 1, 26'h200_1C0A, 1, 0, 0);
    tbl[6]  = mk(0, 1, 7'h04, 1, 0, 1, 26'h200_1C0A, 2, 0, 0);
    tbl[7]  = mk(0, 1, 7'h04, 1, 0, 1, 26'h200_1C0A, 3, 1, 0);
    tbl[8]  = mk(0, 0, 7'h00, 1, 1, 0, 26'h000_0000, 0, 0, 0);
    tbl[9]  = mk(0, 1, 7'h60, 1, 1, 1, 26'h200_0000, 0, 1, 1);
    tbl[10] = mk(0, 0, 7'h00, 0, 0, 1, 26'h200_0000, 0, 1, 0);
    tbl[11] = mk(0, 0, 7'h00, 1, 1, 0, 26'h000_0000, 0, 0, 0);
    tbl[12] = mk(0, 1, 7'h00, 1, 1, 1, 26'h200_0001, 0, 1, 0);
    tbl[13] = mk(0, 0, 7'h00, 1, 1, 0, 26'h000_0000, 0, 0, 0);

    apply_reset_checked();

    for (int i = 0; i < 14; i++) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_opc    = tbl[i].opc;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d:in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d:out_valid", i), 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        check($sformatf("vec%0d:out_ctrl", i), 32'(out_ctrl), 32'(tbl[i].ctrl));
        check($sformatf("vec%0d:out_beat", i), 32'(out_beat), 32'(tbl[i].beat));
        check($sformatf("vec%0d:out_last", i), 32'(out_last), 32'(tbl[i].last));
      end
      check($sformatf("vec%0d:illegal", i), 32'(illegal), 32'(tbl[i].ill));
    end

    // Model-tracked section starts from a fresh reset.
    apply_reset_checked();

    // Backpressure on beat 1 of opc 0x03: word held, five stalled cycles counted.
    cycle("bp_acc", 0, 1, 7'h03, 1);
    cycle("bp_b1", 0, 0, 7'h00, 1);
    check("bp:beat1", 32'(out_beat), 32'd1);
    s0 = m_stall;
    for (int i = 0; i < 5; i++) cycle("bp_stall", 0, 1, 7'h04, 0);
    check("bp:held_beat", 32'(out_beat), 32'd1);
    check("bp:held_ctrl", 32'(out_ctrl), 32'h200_1C06);
`ifdef CTRL_SEQ_PERF_EN
    check("bp:perf_stall_delta", perf_stall, s0 + 32'd5);
`else
    check("bp:perf_stall_off", perf_stall, 32'd0);
`endif
    for (int i = 0; i < 3; i++) cycle("bp_drain", 0, 0, 7'h00, 1);
    check("bp:drained", 32'(out_valid), 32'd0);

    // Flush on beat 1 of opc 0x03 with a pending opcode that must not be taken.
    cycle("fl_acc", 0, 1, 7'h03, 1);
    cycle("fl_b1", 0, 0, 7'h00, 1);
    cycle("fl_flush", 1, 1, 7'h04, 1);
    check("fl:out_valid", 32'(out_valid), 32'd0);
    cycle("fl_next", 0, 1, 7'h05, 1);
    check("fl:next_beat", 32'(out_beat), 32'd0);
    check("fl:next_ctrl", 32'(out_ctrl), 32'h200_140B);
    cycle("fl_d1", 0, 0, 7'h00, 1);
    cycle("fl_d2", 0, 0, 7'h00, 1);

    // Async reset in the middle of a 4-beat burst.
    cycle("rst_acc", 0, 1, 7'h07, 1);
    cycle("rst_b1", 0, 0, 7'h00, 1);
    cycle("rst_b2", 0, 0, 7'h00, 1);
    check("rst:at_beat2", 32'(out_beat), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst:async_valid", 32'(out_valid), 32'd0);
    check("rst:async_ctrl", 32'(out_ctrl), 32'd0);
    check("rst:async_beat", 32'(out_beat), 32'd0);
    check("rst:async_last", 32'(out_last), 32'd0);
    check("rst:async_perf", perf_instr, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("rst:in_ready_after", 32'(in_ready), 32'd1);
    cycle("rst_after", 0, 0, 7'h00, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0),
            7'($urandom_range(0, 127)),
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
